// File: rtl/weight_stream_memory.sv
`default_nettype none
// ============================================================================
// Module   : weight_stream_memory
// Brief    : Single-port-load weight SRAM with a burst streaming read port.
//            Bursts read consecutive words (wrapping at DEPTH) into a 2-entry
//            output FIFO under ready/valid flow control.
//            Optional macro WMEM_PARITY_EN adds per-word even parity and
//            the par_err output.
// Revision : 1.0 - initial release
// ============================================================================
module weight_stream_memory #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 18432,
    parameter int AW     = 15,
    parameter int LW     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [LW-1:0]     req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef WMEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam logic [1:0]    S_IDLE      = 2'd0;
    localparam logic [1:0]    S_STREAM    = 2'd1;
    localparam logic [1:0]    S_DRAIN     = 2'd2;
    localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef WMEM_PARITY_EN
    logic              r_par_mem [DEPTH];
    logic              r_fifo_perr [2];
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_rst_done;
    logic [AW-1:0]     r_rd_addr;
    logic [LW:0]       r_beats;
    logic [LW:0]       r_issue_cnt;
    logic [LW-1:0]     r_last_idx;
    logic [LW-1:0]     r_emit_cnt;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_pop;
    logic              w_last_beat;

    // The SRAM read lands directly in the FIFO slot at the issuing edge, so
    // no read is ever outstanding outside the FIFO occupancy count.
    assign w_accept     = req_valid && req_ready;
    assign w_issue      = (r_state == S_STREAM) && (r_count < 2'd2);
    assign w_issue_last = w_issue && (r_issue_cnt == (r_beats - 1'b1));
    assign w_pop        = out_valid && out_ready;
    assign w_last_beat  = w_pop && out_last;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo_data[r_rp];
    assign out_last  = out_valid && (r_emit_cnt == r_last_idx);
    assign req_ready = r_rst_done && (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE) || out_valid;
`ifdef WMEM_PARITY_EN
    assign par_err   = out_valid && r_fifo_perr[r_rp];
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)     w_state_nxt = S_STREAM;
            S_STREAM: if (w_issue_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_last_beat)  w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Storage array: never reset so contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < c_depth)) begin
            r_mem[wr_addr]     <= wr_data;
`ifdef WMEM_PARITY_EN
            r_par_mem[wr_addr] <= ^wr_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rst_done  <= 1'b0;
            r_rd_addr   <= '0;
            r_beats     <= '0;
            r_issue_cnt <= '0;
            r_last_idx  <= '0;
            r_emit_cnt  <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_state    <= w_state_nxt;
            if (w_accept) begin
                r_rd_addr   <= req_addr;
                r_beats     <= {1'b0, req_len} + 1'b1;
                r_last_idx  <= req_len;
                r_issue_cnt <= '0;
                r_emit_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_addr   <= (r_rd_addr == c_last_addr) ? '0 : r_rd_addr + 1'b1;
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_pop) begin
                    r_emit_cnt <= r_emit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
`ifdef WMEM_PARITY_EN
                r_fifo_perr[i] <= 1'b0;
`endif
            end
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_issue) begin
                r_fifo_data[r_wp] <= r_mem[r_rd_addr];
`ifdef WMEM_PARITY_EN
                r_fifo_perr[r_wp] <= (^r_mem[r_rd_addr]) ^ r_par_mem[r_rd_addr];
`endif
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_count <= r_count + 2'(w_issue) - 2'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: doc/weight_stream_memory.md
WEIGHT_STREAM_MEMORY -- requirements
Module: weight_stream_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one weight word.
REQ-002 SHALL have parameter DEPTH, default 18432: number of words stored.
REQ-003 SHALL have parameter AW, default 15: address width, with DEPTH <= 2**AW.
REQ-004 SHALL have parameter LW, default 15: width of the burst-length field.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, DATA_W): the DMA/CPU load port.
REQ-008 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_addr (input, AW) and req_len (input, LW): burst request, where req_len is the beat count minus 1.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W) and out_last (output, 1): the streamed weight output.
REQ-010 SHALL have port busy, output, 1: high while a burst is in progress or output data is still buffered.

Function
REQ-011 A write SHALL update mem[wr_addr] at the clock edge; a write to an address >= DEPTH SHALL be ignored.
REQ-012 The FSM states SHALL be IDLE, STREAM and DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE->STREAM on req_valid&&req_ready: latch the start address and beat count req_len+1, and zero the issue and emit counters.
REQ-014 In STREAM, one SRAM read per cycle SHALL be issued when (FIFO occupancy + reads in flight) < 2; SRAM read latency is 1 cycle into a 2-entry output FIFO.
REQ-015 The read address SHALL increment per issued read and wrap from DEPTH-1 to 0.
REQ-016 STREAM->DRAIN SHALL occur when the last read has issued; DRAIN->IDLE SHALL occur when the last beat completes (out_valid&&out_ready&&out_last).
REQ-017 out_valid SHALL equal "FIFO not empty"; out_data/out_last SHALL come from the FIFO head and hold stable while out_valid&&!out_ready.
REQ-018 out_last SHALL be 1 only on beat number req_len (counting from 0).
REQ-019 Timing: acceptance in cycle T, first read in T+1, out_valid=1 in T+2; with out_ready held at 1, one beat per cycle with no bubbles.
REQ-020 If a write and a read hit the same address in the same cycle, the read SHALL return the old data.
REQ-021 req_len=0 SHALL produce exactly one beat with out_last=1; req_len=DEPTH-1 SHALL read every word once.
REQ-022 busy SHALL be 1 whenever state!=IDLE or FIFO not empty.
REQ-023 Memory contents SHALL be undefined until written; the SRAM array SHALL be neither reset nor initialised by logic.

Reset
REQ-024 While rst=1: state=IDLE, FIFO emptied, counters=0, out_valid=0, out_last=0, out_data=0, busy=0, req_ready=0.
REQ-025 After rst deasserts: req_ready=1 from the next cycle.
REQ-026 Reset mid-burst SHALL abort the burst with no further beats; memory contents SHALL be retained.

Configuration
REQ-027 Macro WMEM_PARITY_EN SHALL enable per-word parity.
REQ-028 With WMEM_PARITY_EN defined:
- each word stores an even-parity bit computed on write;
- output port par_err (1 bit) accompanies out_data and is 1 when the stored parity mismatches the data;
- par_err resets to 0;
- a parity error SHALL NOT stop the stream.
REQ-029 Without WMEM_PARITY_EN: no par_err port and no parity storage.

Verification
REQ-030 Write mem[0..3]=0xA0..0xA3; request addr=0, len=3, out_ready=1 -> beats A0,A1,A2,A3 in cycles T+2..T+5, out_last only on A3, req_ready=1 by T+6.
REQ-031 Same burst with out_ready toggling 1,0,0,1,... -> no beat lost or duplicated, out_data stable while stalled, at most 2 words buffered.
REQ-032 DEPTH=18432: request addr=18430, len=3 -> data of words 18430, 18431, 0, 1.
REQ-033 Write 0x55 to addr 5 in the same cycle the burst reads addr 5 (old value 0x11) -> beat = 0x11; a following burst returns 0x55.
REQ-034 rst pulsed during beat 2 of a 10-beat burst -> out_valid=0 and busy=0 immediately; a new request after reset is served normally.
REQ-035 With WMEM_PARITY_EN: force a stored parity bit flip at addr 7, burst over 6..8 -> par_err=1 only on the beat for addr 7.
